pwm_peripheral: RTL and testbench
=================================

# pwm_peripheral

Consumes the five configuration bytes written over SPI and drives 16 output pins. Each pin is forced low, driven high, or driven with a shared 8-bit duty-cycle PWM waveform. The block sits directly downstream of the SPI register file, and its pin outputs go straight to the chip's output and bidirectional pads. Configuration is double-buffered and takes effect only at PWM period boundaries, so a mid-period SPI write never produces a runt pulse.

## Interface
- CLK_DIV, default 13: prescaler ratio. The PWM counter advances once every CLK_DIV clk cycles. At a 10 MHz clk, one period is 256 × 13 = 3328 cycles, about 3.0 kHz.
- clk, input, 1: system clock. All state is on the rising edge.
- rst_n, input, 1: reset. One clock; reset is asynchronous and active-low.
- en_reg_out_7_0, input, 8: output-enable bits for pins 7..0.
- en_reg_out_15_8, input, 8: output-enable bits for pins 15..8.
- en_reg_pwm_7_0, input, 8: PWM-mode bits for pins 7..0.
- en_reg_pwm_15_8, input, 8: PWM-mode bits for pins 15..8.
- pwm_duty_cycle, input, 8: shared duty value. 0x00 is always low; 0xFF is always high.
- out_7_0, output, 8: pin drive for pins 7..0. Registered.
- out_15_8, output, 8: pin drive for pins 15..8. Registered.
- period_start, output, 1: one-cycle pulse in the cycle after the shadow registers load. Registered.

## Operation
- **Prescaler:** `presc` counts 0..CLK_DIV-1 and then wraps. `tick` is asserted when `presc == CLK_DIV-1`.
- **PWM counter:** `pcnt` is 8 bits. It increments on `tick` and wraps from 255 to 0. Each value is held for exactly CLK_DIV cycles.
- **Boundary:** `tick && pcnt == 255`. In that same edge, `pcnt` goes to 0 and all five shadow registers load from the inputs. The inputs are already synchronous to clk, so no resynchronisation is needed.
- **PWM signal:** `pwm = (sh_duty == 8'hFF) | (pcnt < sh_duty)`, an unsigned 8-bit compare.
- **Per-pin drive for pin i (0..15):**
  - `sh_en_out[i] == 0`: drive 0, regardless of the PWM bit.
  - `sh_en_out[i] == 1` and `sh_en_pwm[i] == 0`: drive 1.
  - `sh_en_out[i] == 1` and `sh_en_pwm[i] == 1`: drive `pwm`.
- **Output register:** out_7_0 and out_15_8 are registered each clk from the combinational drive above.
- **Reset values:**
  - presc = 0, pcnt = 0.
  - All shadows = 0.
  - out_7_0 = 0x00, out_15_8 = 0x00, period_start = 0.
- **Effect of reset on outputs:** all pins stay low until the first boundary after reset release, even if the inputs are already non-zero.
- **Reset mid-operation:** all state clears immediately (asynchronously). Counting restarts from 0 on the first edge after release.
- **No FSM beyond counters:** the input-to-shadow path is the only hand-off. The inputs may change on any cycle, and only the value present at the boundary edge is captured.

## Timing
- **First boundary:** after rst_n deasserts, the first boundary edge is rising edge number 256 × CLK_DIV (edge 3328 for the default).
  - Shadows load on that edge.
  - Outputs reflect the new configuration one edge later (edge 3329).
  - period_start is high for exactly one cycle after edge 3329.
- **Boundary spacing:** subsequent boundaries are every 256 × CLK_DIV edges.
- **Output latency:** 1 cycle from the `pcnt`/shadow state to the pins.
- **High time per period:** sh_duty × CLK_DIV cycles for duty values 1..254. Duty 0 gives 0 cycles; duty 255 gives the full period.
- **Edge positions:** within a period, the rising edge of the pin follows the boundary by 1 cycle. The falling edge comes duty × CLK_DIV cycles later.
- **Input change on the boundary edge:** the value sampled at that edge wins. A change one cycle after the boundary is deferred a full period.
- **CLK_DIV = 1 is legal:** tick is then asserted every cycle and the period is 256 cycles.

## Test plan
1. **PWM duty 0x80:** after reset, set en_reg_out_7_0 = 0x01, en_reg_pwm_7_0 = 0x01, duty = 0x80, with CLK_DIV = 13. Required after the first boundary: out_7_0[0] is high for 1664 cycles and low for 1664 cycles, repeating every 3328 cycles. All other pins stay 0.
2. **Duty extremes:** in the same setup, duty = 0x00 holds the pin low for the whole period, and duty = 0xFF holds it high continuously with no low cycle, including across the wrap.
3. **Static and disabled pins:** en_reg_out_15_8 = 0xF0, en_reg_pwm_15_8 = 0x00, en_reg_out_7_0 = 0x00, en_reg_pwm_7_0 = 0xFF, duty = 0x40. Required after the first boundary: out_15_8 = 0xF0 constant and out_7_0 = 0x00 constant. Enabling PWM mode alone does not drive a pin.
4. **Mid-period write is deferred:** running at duty 0x40, write duty 0xC0 at pcnt = 0x50. Required: the current period still has a 0x40 × 13 = 832-cycle high time. The next period has 2496 cycles high. No glitch occurs at the write.
5. **Reset mid-period:** assert rst_n low for 3 cycles while a pin is high. Required: the pins and period_start go to 0 asynchronously. After release, the pins stay 0 for 3328 edges, then resume with the shadowed configuration.
6. **period_start cadence:** with CLK_DIV = 1, period_start pulses exactly once every 256 cycles, and each pulse is one cycle wide.

Source files
------------

// File: rtl/pwm_peripheral_if.sv
// -----------------------------------------------------------------------------
// pwm_peripheral_if
//   Groups the configuration bytes coming from the SPI register file and the
//   pin drive going out to the pads into one bundle.
//
//   Signals
//     en_reg_out_7_0 / en_reg_out_15_8 : output-enable bits, pins 7..0 / 15..8
//     en_reg_pwm_7_0 / en_reg_pwm_15_8 : PWM-mode bits, pins 7..0 / 15..8
//     pwm_duty_cycle                   : shared 8-bit duty value
//     out_7_0 / out_15_8               : registered pin drive
//     period_start                     : one-cycle pulse after a shadow load
//
//   Modports
//     master : register-file side (drives configuration, observes pins)
//     slave  : the PWM peripheral itself
// -----------------------------------------------------------------------------
interface pwm_peripheral_if;
   logic [7:0] en_reg_out_7_0;
   logic [7:0] en_reg_out_15_8;
   logic [7:0] en_reg_pwm_7_0;
   logic [7:0] en_reg_pwm_15_8;
   logic [7:0] pwm_duty_cycle;
   logic [7:0] out_7_0;
   logic [7:0] out_15_8;
   logic       period_start;

   modport master (
      output en_reg_out_7_0, en_reg_out_15_8,
      output en_reg_pwm_7_0, en_reg_pwm_15_8,
      output pwm_duty_cycle,
      input  out_7_0, out_15_8, period_start
   );

   modport slave (
      input  en_reg_out_7_0, en_reg_out_15_8,
      input  en_reg_pwm_7_0, en_reg_pwm_15_8,
      input  pwm_duty_cycle,
      output out_7_0, out_15_8, period_start
   );
endinterface

// File: rtl/pwm_peripheral.sv
// -----------------------------------------------------------------------------
// pwm_peripheral
//   Drives 16 pins, each forced low, driven high, or driven with a shared
//   8-bit duty-cycle PWM waveform. Configuration is double-buffered: the
//   shadow registers only load at a PWM period boundary, so a configuration
//   write in the middle of a period can never produce a runt pulse.
//
//   Parameters
//     CLK_DIV : prescaler ratio (>= 1); the PWM counter advances once every
//               CLK_DIV clk cycles, one period is 256 * CLK_DIV cycles.
//
//   Ports
//     clk   : system clock, rising edge
//     rst_n : asynchronous active-low reset
//     bus   : pwm_peripheral_if.slave (configuration in, pin drive out)
// -----------------------------------------------------------------------------
module pwm_peripheral #(
   parameter int CLK_DIV = 13
) (
   input  logic             clk,
   input  logic             rst_n,
   pwm_peripheral_if.slave  bus
);

   // A one-bit prescaler is kept for CLK_DIV = 1; it then stays at 0 and
   // tick is asserted every cycle.
   localparam int            PW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);

   logic [PW-1:0] presc;
   logic [7:0]    pcnt;
   logic          tick;
   logic          boundary;

   logic [15:0]   sh_en_out;
   logic [15:0]   sh_en_pwm;
   logic [7:0]    sh_duty;

   logic          load_q;
   logic          pwm;
   logic [15:0]   drive;

   assign tick     = (presc == PRESC_LAST);
   assign boundary = tick && (pcnt == 8'hFF);

   // ---------------------------------------------------------------------------
   // Prescaler and PWM counter
   // ---------------------------------------------------------------------------
   // NOTE: state registers use non-blocking assignments so every always_ff
   // samples the pre-edge values of the others, independent of block order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc <= '0;
         pcnt  <= '0;
      end else begin
         if (tick) begin
            presc <= '0;
            pcnt  <= pcnt + 8'd1;   // 255 wraps to 0 on the boundary edge
         end else begin
            presc <= presc + PW'(1);
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Shadow registers: capture whatever the inputs hold on the boundary edge.
   // ---------------------------------------------------------------------------
   // NOTE: the shadows are reset to zero on purpose; that is what keeps every
   // pin low until the first boundary after reset, whatever the inputs hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_en_out <= '0;
         sh_en_pwm <= '0;
         sh_duty   <= '0;
      end else if (boundary) begin
         sh_en_out <= {bus.en_reg_out_15_8, bus.en_reg_out_7_0};
         sh_en_pwm <= {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0};
         sh_duty   <= bus.pwm_duty_cycle;
      end
   end

   // ---------------------------------------------------------------------------
   // Waveform and per-pin drive
   // ---------------------------------------------------------------------------
   // Duty 0xFF is special-cased so the pin stays high through pcnt = 255 and
   // across the wrap; otherwise the compare alone could never reach 100 %.
   always_comb begin
      pwm   = (sh_duty == 8'hFF) | (pcnt < sh_duty);
      // Disabled pins are 0; enabled static pins are 1; enabled PWM pins follow pwm.
      drive = sh_en_out & (~sh_en_pwm | {16{pwm}});
   end

   // ---------------------------------------------------------------------------
   // Output registers. load_q delays the boundary by one cycle so that
   // period_start lines up with the first pin value of the new configuration.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.out_7_0      <= 8'h00;
         bus.out_15_8     <= 8'h00;
         load_q           <= 1'b0;
         bus.period_start <= 1'b0;
      end else begin
         bus.out_7_0      <= drive[7:0];
         bus.out_15_8     <= drive[15:8];
         load_q           <= boundary;
         bus.period_start <= load_q;
      end
   end

endmodule

// File: tb/tb_pwm_peripheral.sv
// -----------------------------------------------------------------------------
// tb_pwm_peripheral
//   Self-checking bench for pwm_peripheral. dut_a runs at CLK_DIV = 13 and
//   carries the functional scenarios; dut_b runs at CLK_DIV = 1 for the
//   period_start cadence. Each configuration is pushed to a scoreboard when
//   it is driven and popped when the period it governs is observed on the
//   pins, where it is compared sample by sample against the expected drive.
// -----------------------------------------------------------------------------
module tb_pwm_peripheral;

   localparam int D = 13;
   localparam int P = 256 * D;

   typedef struct {
      string       tag;
      logic [15:0] en_out;
      logic [15:0] en_pwm;
      logic [7:0]  duty;
   } cfg_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   pwm_peripheral_if bus_a ();
   pwm_peripheral_if bus_b ();

   pwm_peripheral #(.CLK_DIV(D)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
   pwm_peripheral #(.CLK_DIV(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

   int   tests_run    = 0;
   int   tests_failed = 0;
   cfg_t sb[$];

   // Rising edges since reset release.
   int unsigned edge_cnt;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) edge_cnt <= 0;
      else        edge_cnt <= edge_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] pins_a();
      return {bus_a.out_15_8, bus_a.out_7_0};
   endfunction

   // Expected pin vector at sample j of a period (j = 0 is the first sample
   // after the boundary, where the new configuration first appears).
   function automatic logic [15:0] expect_pins(input cfg_t c, input int j);
      logic high;
      high = (c.duty == 8'hFF) || (j < int'(c.duty) * D);
      return c.en_out & (~c.en_pwm | {16{high}});
   endfunction

   // High time of pin 0 over one period, from the closed-form description.
   function automatic int expect_hi0(input cfg_t c);
      if (!c.en_out[0])        return 0;
      if (!c.en_pwm[0])        return P;
      if (c.duty == 8'hFF)     return P;
      return int'(c.duty) * D;
   endfunction

   function automatic cfg_t mk(input string tag, input logic [15:0] eo,
                               input logic [15:0] ep, input logic [7:0] d);
      cfg_t c;
      c.tag = tag; c.en_out = eo; c.en_pwm = ep; c.duty = d;
      return c;
   endfunction

   task automatic drive_cfg(input cfg_t c);
      bus_a.en_reg_out_7_0  = c.en_out[7:0];
      bus_a.en_reg_out_15_8 = c.en_out[15:8];
      bus_a.en_reg_pwm_7_0  = c.en_pwm[7:0];
      bus_a.en_reg_pwm_15_8 = c.en_pwm[15:8];
      bus_a.pwm_duty_cycle  = c.duty;
      sb.push_back(c);
   endtask

   // Wait (bounded) for the first period_start after reset release; pins must
   // stay low the whole time and the pulse must follow edge P + 1.
   task automatic wait_first(input string tag);
      int nz;
      nz = 0;
      for (int i = 0; i < P + 20; i++) begin
         @(negedge clk);
         if (bus_a.period_start === 1'b1) break;
         if (pins_a() !== 16'h0000) nz++;
      end
      check({tag, ".first_edge"}, edge_cnt, P + 1);
      check({tag, ".low_before"}, nz, 0);
   endtask

   // Observe one full period. With aligned = 1 the current negedge is already
   // sample 0; otherwise the next negedge is. Optionally writes a new duty at
   // sample mid_at, and drives (and pushes) the next configuration shortly
   // before the closing boundary.
   task automatic run_period(input bit aligned, input cfg_t next,
                             input int mid_at, input logic [7:0] mid_duty);
      cfg_t        cur;
      int          mism, hi0, ps_cnt, ps_first;
      logic [15:0] obs;
      if (sb.size() == 0) begin
         check("scoreboard_empty", 0, 1);
         return;
      end
      cur      = sb.pop_front();
      mism     = 0;
      hi0      = 0;
      ps_cnt   = 0;
      ps_first = -1;
      for (int j = 0; j < P; j++) begin
         if (j > 0 || !aligned) @(negedge clk);
         obs = pins_a();
         if (obs !== expect_pins(cur, j)) mism++;
         if (obs[0] === 1'b1) hi0++;
         if (bus_a.period_start === 1'b1) begin
            ps_cnt++;
            if (ps_first < 0) ps_first = j;
         end
         if (j == mid_at)  bus_a.pwm_duty_cycle = mid_duty;
         if (j == P - 10)  drive_cfg(next);
      end
      check({cur.tag, ".pins"},    mism,     0);
      check({cur.tag, ".hi0"},     hi0,      expect_hi0(cur));
      check({cur.tag, ".ps_cnt"},  ps_cnt,   1);
      check({cur.tag, ".ps_pos"},  ps_first, 0);
   endtask

   localparam logic [15:0] A_EN = 16'h0001;

   initial begin
      int pulses, wide, last;
      logic prev;

      bus_a.en_reg_out_7_0  = '0; bus_a.en_reg_out_15_8 = '0;
      bus_a.en_reg_pwm_7_0  = '0; bus_a.en_reg_pwm_15_8 = '0;
      bus_a.pwm_duty_cycle  = '0;
      bus_b.en_reg_out_7_0  = 8'hFF; bus_b.en_reg_out_15_8 = 8'hFF;
      bus_b.en_reg_pwm_7_0  = 8'h00; bus_b.en_reg_pwm_15_8 = 8'h00;
      bus_b.pwm_duty_cycle  = 8'h00;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst.pins_a", pins_a(), 16'h0000);
      check("rst.ps_a",   bus_a.period_start, 1'b0);
      check("rst.pins_b", {bus_b.out_15_8, bus_b.out_7_0}, 16'h0000);
      rst_n = 1'b1;

      // Duty 0x80, extremes, static/disabled pins, deferred writes
      drive_cfg(mk("t1_d80", A_EN, A_EN, 8'h80));
      wait_first("boot");
      run_period(1'b1, mk("t2_d00",      A_EN,     A_EN,     8'h00), -1, 8'h00);
      run_period(1'b0, mk("t2_dff",      A_EN,     A_EN,     8'hFF), -1, 8'h00);
      run_period(1'b0, mk("t2_dff_wrap", A_EN,     A_EN,     8'hFF), -1, 8'h00);
      run_period(1'b0, mk("t3_static",   16'hF000, 16'h00FF, 8'h40), -1, 8'h00);
      run_period(1'b0, mk("t4_d40",      A_EN,     A_EN,     8'h40), -1, 8'h00);
      // Write 0xC0 at pcnt = 0x50 of the 0x40 period: takes effect next period.
      run_period(1'b0, mk("t4_dc0",      A_EN,     A_EN,     8'hC0), 16'h50 * D, 8'hC0);
      // Write 0x10 one cycle after the boundary: deferred a full period.
      run_period(1'b0, mk("t4_d10",      A_EN,     A_EN,     8'h10), 0, 8'h10);
      run_period(1'b0, mk("t5_pre",      A_EN,     A_EN,     8'hFF), -1, 8'h00);

      // Reset mid-operation, at the first sample of a period (pin and
      // period_start both high).
      @(negedge clk);
      check("t5.pin_high", bus_a.out_7_0[0], 1'b1);
      check("t5.ps_high",  bus_a.period_start, 1'b1);
      rst_n = 1'b0;
      #1;
      check("t5.async_pins", pins_a(), 16'h0000);
      check("t5.async_ps",   bus_a.period_start, 1'b0);
      repeat (3) @(negedge clk);
      sb.delete();
      rst_n = 1'b1;
      drive_cfg(mk("t5_post", A_EN, A_EN, 8'hFF));
      wait_first("post_rst");
      run_period(1'b1, mk("t5_tail", A_EN, A_EN, 8'hFF), -1, 8'h00);

      // period_start cadence at CLK_DIV = 1
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (bus_b.period_start === 1'b1) break;
      end
      check("t6.first", bus_b.period_start, 1'b1);
      pulses = 0; wide = 0; last = 0; prev = 1'b1;
      for (int s = 1; s <= 768; s++) begin
         @(negedge clk);
         if (bus_b.period_start === 1'b1) begin
            pulses++;
            if (prev === 1'b1) wide++;
            check("t6.gap", s - last, 256);
            last = s;
         end
         prev = bus_b.period_start;
      end
      check("t6.pulses", pulses, 3);
      check("t6.wide",   wide,   0);
      check("t6.pins",   {bus_b.out_15_8, bus_b.out_7_0}, 16'hFFFF);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
